// File: rtl/button_debouncer_if.sv
// Button debouncer signal bundle: raw button in, debounced level and busy flag out.
// The master modport drives the button; the slave modport is the debouncer itself.
interface button_debouncer_if;
    logic PB;
    logic LP;
    logic busy;

    modport master (output PB, input LP, input busy);
    modport slave  (input PB, output LP, output busy);
endinterface

// File: rtl/button_debouncer.sv
// Push-button debouncer: optional 2-flop synchronizer feeding a counter-qualified 4-state FSM.
// Define DEBOUNCER_SYNC_EN to insert the synchronizer (required for off-chip PB).
module button_debouncer #(
    parameter int   STABLE_CYCLES = 50000,
    parameter int   CNT_W         = 16,
    parameter logic RST_LEVEL     = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    button_debouncer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_HI = 2'd0,
        W_LO = 2'd1,
        S_LO = 2'd2,
        W_HI = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_lp;
    logic             r_busy;
    logic             w_sample;

`ifdef DEBOUNCER_SYNC_EN
    logic [1:0] r_sync;

    // Two-flop synchronizer; flops park at the idle level so reset never looks like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {2{RST_LEVEL}};
        end else begin
            r_sync <= {r_sync[0], bus.PB};
        end
    end

    assign w_sample = r_sync[1];
`else
    assign w_sample = bus.PB;
`endif

    // Qualification FSM; LP/busy are registered alongside the state so they never see PB directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= (RST_LEVEL == 1'b1) ? S_HI : S_LO;
            r_cnt   <= '0;
            r_lp    <= RST_LEVEL;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_HI: begin
                    r_cnt <= '0;
                    if (w_sample == 1'b0) begin
                        r_state <= W_LO;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_HI;
                    end
                end
                W_LO: begin
                    if (w_sample == 1'b1) begin
                        r_state <= S_HI;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= S_LO;
                        r_cnt   <= '0;
                        r_lp    <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_LO: begin
                    r_cnt <= '0;
                    if (w_sample == 1'b1) begin
                        r_state <= W_HI;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_LO;
                    end
                end
                W_HI: begin
                    if (w_sample == 1'b0) begin
                        r_state <= S_LO;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= S_HI;
                        r_cnt   <= '0;
                        r_lp    <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= (RST_LEVEL == 1'b1) ? S_HI : S_LO;
                    r_cnt   <= '0;
                    r_lp    <= RST_LEVEL;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.LP   = r_lp;
    assign bus.busy = r_busy;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer (STABLE_CYCLES=4 main DUT, STABLE_CYCLES=1 side DUT);
// expected edge timing follows the latency rules with SYNC taken from DEBOUNCER_SYNC_EN.
module tb_button_debouncer;

    localparam int STABLE = 4;
`ifdef DEBOUNCER_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic clk;
    logic rst;

    button_debouncer_if bif ();
    button_debouncer_if bif1 ();

    button_debouncer #(.STABLE_CYCLES(STABLE), .CNT_W(3), .RST_LEVEL(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    button_debouncer #(.STABLE_CYCLES(1), .CNT_W(1), .RST_LEVEL(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bif1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic pb;
        logic rst;
        logic exp_lp;
        logic exp_busy;
        int   tag;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input int idx, input logic act, input logic exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    function automatic void add_vec(input logic pb, input logic r, input logic lp,
                                    input logic busy, input int tag);
        vec_t v;
        v.pb = pb; v.rst = r; v.exp_lp = lp; v.exp_busy = busy; v.tag = tag;
        vecs.push_back(v);
    endfunction

    // Short low pulse of len cycles from S_HI: busy for len cycles, LP never moves.
    function automatic void add_pulse(input int len, input int tag);
        for (int k = 1; k <= len + SYNC + 2; k++) begin
            add_vec((k <= len) ? 1'b0 : 1'b1, 1'b0, 1'b1,
                    (k >= 1 + SYNC && k <= len + SYNC) ? 1'b1 : 1'b0, tag);
        end
    endfunction

    // Held step to new_pb: busy edges 1+SYNC..STABLE+SYNC, LP flips at edge STABLE+1+SYNC.
    function automatic void add_step(input logic new_pb, input int tag);
        for (int k = 1; k <= STABLE + SYNC + 2; k++) begin
            add_vec(new_pb, 1'b0, (k >= STABLE + 1 + SYNC) ? new_pb : ~new_pb,
                    (k >= 1 + SYNC && k <= STABLE + SYNC) ? 1'b1 : 1'b0, tag);
        end
    endfunction

    task automatic drive(input logic pb, input logic r);
        bif.PB  = pb;
        bif1.PB = pb;
        rst     = r;
    endtask

    initial begin
        string tag_name [5] = '{"reset", "glitch2", "glitch3", "fall", "rise"};

        add_vec(1'b1, 1'b1, 1'b1, 1'b0, 0);
        add_vec(1'b1, 1'b1, 1'b1, 1'b0, 0);
        add_pulse(2, 1);
        add_pulse(STABLE - 1, 2);
        add_step(1'b0, 3);
        add_step(1'b1, 4);

        drive(1'b1, 1'b1);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].pb, vecs[i].rst);
            @(posedge clk);
            #1;
            check({tag_name[vecs[i].tag], ".LP"},   i, bif.LP,   vecs[i].exp_lp);
            check({tag_name[vecs[i].tag], ".busy"}, i, bif.busy, vecs[i].exp_busy);
        end

        // Reset lands mid-qualification (cnt=2) and must win over the pending fall.
        drive(1'b0, 1'b0);
        for (int k = 1; k <= 3 + SYNC; k++) begin
            @(posedge clk);
        end
        #1;
        check("midqual.busy", 0, bif.busy, 1'b1);
        drive(1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("rst_mid.LP",   0, bif.LP,   1'b1);
        check("rst_mid.busy", 0, bif.busy, 1'b0);
        check("rst1.LP",      0, bif1.LP,  1'b1);

        // After release the full latency repeats; the STABLE_CYCLES=1 DUT waits exactly one cycle.
        drive(1'b0, 1'b0);
        for (int k = 1; k <= STABLE + SYNC + 2; k++) begin
            @(posedge clk);
            #1;
            check("rerun.LP",   k, bif.LP,   (k >= STABLE + 1 + SYNC) ? 1'b0 : 1'b1);
            check("rerun.busy", k, bif.busy, (k >= 1 + SYNC && k <= STABLE + SYNC) ? 1'b1 : 1'b0);
            check("sc1.LP",     k, bif1.LP,  (k >= 2 + SYNC) ? 1'b0 : 1'b1);
            check("sc1.busy",   k, bif1.busy, (k == 1 + SYNC) ? 1'b1 : 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
